// File: rtl/servo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : servo_pkg
// Description : Shared constants and state encoding for the hobby-servo PWM
//               driver. Timing defaults describe a 50 MHz system clock driving
//               a standard 50 Hz servo frame with a 1..2 ms pulse.
// Revision    : 1.0 - initial release
// ============================================================================
package servo_pkg;

  // Default timing constants
  localparam int unsigned C_CLK_FREQ     = 50_000_000;
  localparam int unsigned C_FRAME_HZ     = 50;
  localparam int unsigned C_MIN_PULSE_US = 1000;
  localparam int unsigned C_MAX_PULSE_US = 2000;

  // Angle range and post-reset position
  localparam int unsigned C_ANGLE_MAX    = 180;
  localparam int unsigned C_ANGLE_HOME   = 90;

  // Default slew limit in degrees per frame (0 = jump straight to target)
  localparam int unsigned C_SLEW_STEP    = 4;

  // Frame sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

endpackage : servo_pkg
`default_nettype wire

// File: rtl/servo_slew_step.sv
`default_nettype none
// ============================================================================
// Module      : servo_slew_step
// Description : Combinational slew limiter. Moves the current angle toward the
//               target by at most i_step degrees, never overshooting. A step
//               of zero disables limiting and returns the target directly.
// Ports       : i_cur      - current commanded angle
//               i_tgt      - (already clamped) target angle
//               i_step     - maximum change allowed in one frame
//               o_next_cur - angle to command for the next frame
//               o_reached  - o_next_cur equals i_tgt
// Revision    : 1.0 - initial release
// ============================================================================
module servo_slew_step
  import servo_pkg::*;
(
  input  logic [7:0] i_cur,
  input  logic [7:0] i_tgt,
  input  logic [7:0] i_step,
  output logic [7:0] o_next_cur,
  output logic       o_reached
);

  logic [7:0] w_up_dist;
  logic [7:0] w_dn_dist;

  // Only the difference in the actual direction of travel is ever used, so the
  // wrap-around of the opposite subtraction is harmless.
  assign w_up_dist = i_tgt - i_cur;
  assign w_dn_dist = i_cur - i_tgt;

  always_comb begin
    o_next_cur = i_tgt;
    if (i_step != 8'd0) begin
      if (i_tgt > i_cur) begin
        if (w_up_dist > i_step) begin
          o_next_cur = i_cur + i_step;
        end
      end else if (w_dn_dist > i_step) begin
        o_next_cur = i_cur - i_step;
      end
    end
  end

  assign o_reached = (o_next_cur == i_tgt);

endmodule : servo_slew_step
`default_nettype wire

// File: rtl/servo_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module      : servo_pwm_driver
// Description : Converts an angle in degrees into a hobby-servo PWM frame.
//               The request is sampled once per frame, clamped to ANGLE_MAX
//               and slew-limited before it sets the pulse width.
// Ports       : clk          - system clock
//               rst          - asynchronous active-high reset
//               i_enable     - run PWM frames while high (checked at frame
//                              wrap and while idle)
//               i_angle_in   - requested angle in degrees
//               o_servo_pwm  - registered PWM output
//               o_cur_angle  - commanded angle for the current frame
//               o_at_target  - commanded angle equals last sampled request
//               o_frame_tick - one-cycle pulse on the first cycle of a frame
// Revision    : 1.0 - initial release
// ============================================================================
module servo_pwm_driver
  import servo_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = C_CLK_FREQ,
  parameter int unsigned FRAME_HZ     = C_FRAME_HZ,
  parameter int unsigned MIN_PULSE_US = C_MIN_PULSE_US,
  parameter int unsigned MAX_PULSE_US = C_MAX_PULSE_US,
  parameter int unsigned ANGLE_MAX    = C_ANGLE_MAX,
  parameter int unsigned ANGLE_HOME   = C_ANGLE_HOME,
  parameter int unsigned SLEW_STEP    = C_SLEW_STEP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_enable,
  input  logic [7:0] i_angle_in,
  output logic       o_servo_pwm,
  output logic [7:0] o_cur_angle,
  output logic       o_at_target,
  output logic       o_frame_tick
);

  localparam int unsigned FRAME_TICKS   = CLK_FREQ / FRAME_HZ;
  localparam int unsigned TICKS_PER_US  = CLK_FREQ / 1_000_000;
  localparam int unsigned MIN_TICKS     = MIN_PULSE_US * TICKS_PER_US;
  localparam int unsigned TICKS_PER_DEG =
      ((MAX_PULSE_US - MIN_PULSE_US) * TICKS_PER_US) / ANGLE_MAX;
  localparam int unsigned MAX_TICKS     = MIN_TICKS + ANGLE_MAX * TICKS_PER_DEG;
  localparam int unsigned HOME_TICKS    = MIN_TICKS + ANGLE_HOME * TICKS_PER_DEG;
  localparam int unsigned CW            = $clog2(FRAME_TICKS);

  // The widest pulse must leave at least one low cycle in the frame, and the
  // angle arithmetic is 8-bit.
  generate
    if ((MAX_TICKS >= FRAME_TICKS) || (MIN_TICKS == 0) || (ANGLE_MAX > 255) ||
        (ANGLE_HOME > ANGLE_MAX) || (SLEW_STEP > 255)) begin : g_bad_params
      $error("servo_pwm_driver: illegal timing or angle parameters");
    end
  endgenerate

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_pulse;
  logic [7:0]    r_cur_angle;
  logic          r_at_target;
  logic          r_pwm;
  logic          r_frame_tick;

  logic [7:0]    w_tgt;
  logic [7:0]    w_next_cur;
  logic          w_reached;
  logic [CW-1:0] w_pulse_next;
  logic          w_last;
  logic          w_start;

  assign w_tgt = (i_angle_in > 8'(ANGLE_MAX)) ? 8'(ANGLE_MAX) : i_angle_in;

  servo_slew_step u_slew (
    .i_cur      (r_cur_angle),
    .i_tgt      (w_tgt),
    .i_step     (8'(SLEW_STEP)),
    .o_next_cur (w_next_cur),
    .o_reached  (w_reached)
  );

  // Constant multiply only; the divide in TICKS_PER_DEG is elaboration-time.
  assign w_pulse_next = CW'(MIN_TICKS) + CW'(w_next_cur) * CW'(TICKS_PER_DEG);

  assign w_last  = (r_count == CW'(FRAME_TICKS - 1));
  // A frame begins on leaving idle or on wrap, and only if enable is high then.
  assign w_start = i_enable && ((r_state == S_IDLE) || w_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_pulse      <= CW'(HOME_TICKS);
      r_cur_angle  <= 8'(ANGLE_HOME);
      r_at_target  <= 1'b0;
      r_pwm        <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= 1'b0;
      if (w_start) begin
        // Count 0: latch the new angle and pulse width for the whole frame.
        r_state      <= S_HIGH;
        r_count      <= '0;
        r_frame_tick <= 1'b1;
        r_cur_angle  <= w_next_cur;
        r_pulse      <= w_pulse_next;
        r_at_target  <= w_reached;
        r_pwm        <= 1'b0;
      end else begin
        case (r_state)
          S_HIGH: begin
            r_count <= r_count + CW'(1);
            // Output is registered, so setting it at count c shows at c+1:
            // high exactly for counts 1..r_pulse.
            if (r_count < r_pulse) begin
              r_pwm <= 1'b1;
            end else begin
              r_pwm   <= 1'b0;
              r_state <= S_LOW;
            end
          end
          S_LOW: begin
            r_pwm <= 1'b0;
            if (w_last) begin
              r_count <= '0;
              r_state <= S_IDLE;
            end else begin
              r_count <= r_count + CW'(1);
            end
          end
          default: begin
            r_pwm   <= 1'b0;
            r_count <= '0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_servo_pwm  = r_pwm;
  assign o_cur_angle  = r_cur_angle;
  assign o_at_target  = r_at_target;
  assign o_frame_tick = r_frame_tick;

endmodule : servo_pwm_driver
`default_nettype wire

// File: tb/tb_servo_pwm_driver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_servo_pwm_driver
// Description : Self-checking bench for servo_pwm_driver. Two instances run
//               side by side on the same inputs: one slew-limited (4 deg per
//               frame) and one unlimited. A frame-position reference model
//               predicts every output on every cycle; a stimulus table and a
//               few hand-written sequences cover the corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_servo_pwm_driver;

  localparam int FT     = 1000;  // cycles per frame
  localparam int MINP   = 100;   // pulse at angle 0
  localparam int AMAX   = 180;
  localparam int AHOME  = 90;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] angle = 8'd90;

  logic       pwm4, tick4, at4;
  logic [7:0] cur4;
  logic       pwm0, tick0, at0;
  logic [7:0] cur0;

  int vectors     = 0;
  int miscompares = 0;
  bit finished    = 0;

  always #5 clk = ~clk;

  servo_pwm_driver #(
    .CLK_FREQ(1_000_000), .FRAME_HZ(1000), .MIN_PULSE_US(100),
    .MAX_PULSE_US(280), .ANGLE_MAX(180), .ANGLE_HOME(90), .SLEW_STEP(4)
  ) u_dut4 (
    .clk(clk), .rst(rst), .i_enable(en), .i_angle_in(angle),
    .o_servo_pwm(pwm4), .o_cur_angle(cur4), .o_at_target(at4), .o_frame_tick(tick4)
  );

  servo_pwm_driver #(
    .CLK_FREQ(1_000_000), .FRAME_HZ(1000), .MIN_PULSE_US(100),
    .MAX_PULSE_US(280), .ANGLE_MAX(180), .ANGLE_HOME(90), .SLEW_STEP(0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .i_enable(en), .i_angle_in(angle),
    .o_servo_pwm(pwm0), .o_cur_angle(cur0), .o_at_target(at0), .o_frame_tick(tick0)
  );

  // ---------------------------------------------------------------- reporting
  task automatic finish_run();
    if (!finished) begin
      finished = 1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      if (miscompares >= 50) finish_run();
    end
  endtask

  // ------------------------------------------------------- reference model
  // Index 0 models the slew-limited instance, index 1 the unlimited one.
  function automatic int step_of(input int k);
    return (k == 0) ? 4 : 0;
  endfunction

  function automatic int clamp_angle(input int a);
    return (a > AMAX) ? AMAX : a;
  endfunction

  function automatic int slew(input int cur, input int tgt, input int step);
    int d;
    if (step == 0) return tgt;
    d = tgt - cur;
    if (d > step)  d = step;
    if (d < -step) d = -step;
    return cur + d;
  endfunction

  int m_pos   [2];  // position within the frame, -1 while idle
  int m_cur   [2];
  int m_pulse [2];
  bit m_at    [2];
  bit m_valid = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_pos[k]   <= -1;
        m_cur[k]   <= AHOME;
        m_pulse[k] <= MINP + AHOME;
        m_at[k]    <= 1'b0;
      end
      m_valid <= 1'b1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (en && (m_pos[k] < 0 || m_pos[k] == FT - 1)) begin
          m_pos[k]   <= 0;
          m_cur[k]   <= slew(m_cur[k], clamp_angle(int'(angle)), step_of(k));
          m_pulse[k] <= MINP + slew(m_cur[k], clamp_angle(int'(angle)), step_of(k));
          m_at[k]    <= (slew(m_cur[k], clamp_angle(int'(angle)), step_of(k))
                         == clamp_angle(int'(angle)));
        end else if (m_pos[k] == FT - 1) begin
          m_pos[k] <= -1;
        end else if (m_pos[k] >= 0) begin
          m_pos[k] <= m_pos[k] + 1;
        end
      end
    end
  end

  function automatic int exp_pwm(input int k);
    return (m_pos[k] >= 1 && m_pos[k] <= m_pulse[k]) ? 1 : 0;
  endfunction

  // Cycle-by-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (m_valid && !finished) begin
      check("pwm_s4",  int'(pwm4),  exp_pwm(0));
      check("tick_s4", int'(tick4), (m_pos[0] == 0) ? 1 : 0);
      check("cur_s4",  int'(cur4),  m_cur[0]);
      check("at_s4",   int'(at4),   int'(m_at[0]));
      check("pwm_s0",  int'(pwm0),  exp_pwm(1));
      check("tick_s0", int'(tick0), (m_pos[1] == 0) ? 1 : 0);
      check("cur_s0",  int'(cur0),  m_cur[1]);
      check("at_s0",   int'(at0),   int'(m_at[1]));
    end
  end

  // ------------------------------------------------------------- stimulus
  typedef struct {
    bit rst_first;
    bit en;
    int angle;
    int nframes;
    int cur4;
    bit at4;
    int cur0;
    bit at0;
  } vec_t;

  vec_t tbl [9];

  task automatic wait_ticks(input int n);
    int seen   = 0;
    int budget = n * FT + 2 * FT;
    while (seen < n && budget > 0) begin
      @(negedge clk);
      budget--;
      if (tick4) seen++;
    end
    if (seen < n) check("tick_timeout", seen, n);
  endtask

  initial begin
    int s4, s0, nt;

    //                rst en angle frames cur4 at4 cur0 at0
    tbl[0] = '{0, 1,  90,  2,  90, 1,  90, 1};  // home holds
    tbl[1] = '{0, 1, 255,  1,  94, 0, 180, 1};  // clamp to 180
    tbl[2] = '{0, 1, 255, 21, 178, 0, 180, 1};
    tbl[3] = '{0, 1, 255,  1, 180, 1, 180, 1};  // 23rd frame reaches 180
    tbl[4] = '{0, 1, 200,  2, 180, 1, 180, 1};
    tbl[5] = '{1, 1,   0, 22,   2, 0,   0, 1};  // 90 -> 0 from reset
    tbl[6] = '{0, 1,   0,  1,   0, 1,   0, 1};  // 23rd frame reaches 0
    tbl[7] = '{0, 1,   2,  1,   2, 1,   2, 1};  // short step, no overshoot
    tbl[8] = '{0, 1, 100,  2,  10, 0, 100, 1};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_pwm",  int'(pwm4),  0);
    check("rst_tick", int'(tick4), 0);
    check("rst_at",   int'(at4),   0);
    check("rst_cur",  int'(cur4),  AHOME);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_pwm", int'(pwm4), 0);

    // Table-driven frames
    for (int i = 0; i < 9; i++) begin
      en    = tbl[i].en;
      angle = 8'(tbl[i].angle);
      if (tbl[i].rst_first) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      wait_ticks(tbl[i].nframes);
      check($sformatf("tbl%0d_cur_s4", i), int'(cur4), tbl[i].cur4);
      check($sformatf("tbl%0d_at_s4",  i), int'(at4),  int'(tbl[i].at4));
      check($sformatf("tbl%0d_cur_s0", i), int'(cur0), tbl[i].cur0);
      check($sformatf("tbl%0d_at_s0",  i), int'(at0),  int'(tbl[i].at0));
    end

    // Mid-frame angle changes must not alter the running pulse.
    angle = 8'd160;
    wait_ticks(1);
    angle = 8'd20;
    s4 = 0; s0 = 0;
    for (int i = 1; i < FT; i++) begin
      @(negedge clk);
      s4 += int'(pwm4);
      s0 += int'(pwm0);
      if (i % 50 == 0) angle = (angle == 8'd20) ? 8'd160 : 8'd20;
      if (i == FT - 1) angle = 8'd90;
    end
    check("toggle_width_s4", s4, 114);
    check("toggle_width_s0", s0, 260);
    check("toggle_cur_s0", int'(cur0), 160);

    // Enable dropped at count 50: frame completes, then idles.
    wait_ticks(1);
    s4 = 0; s0 = 0; nt = 0;
    for (int i = 1; i < 1200; i++) begin
      @(negedge clk);
      if (i == 50) en = 1'b0;
      s4 += int'(pwm4);
      s0 += int'(pwm0);
      nt += int'(tick4);
    end
    check("drop_width_s0", s0, 190);
    check("drop_width_s4", s4, 118);
    check("drop_no_tick", nt, 0);
    en = 1'b1;
    @(negedge clk);
    check("reenable_tick", int'(tick4), 1);

    // Reset during the high phase clears the output at once.
    repeat (100) @(negedge clk);
    check("pre_rst_pwm", int'(pwm0), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pwm_s0", int'(pwm0), 0);
    check("async_rst_pwm_s4", int'(pwm4), 0);
    check("async_rst_cur_s4", int'(cur4), AHOME);
    check("async_rst_at_s4",  int'(at4),  0);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    nt = 0; s0 = 0;
    repeat (20) begin
      @(negedge clk);
      nt += int'(tick0);
      s0 += int'(pwm0);
    end
    check("post_rst_idle_tick", nt, 0);
    check("post_rst_idle_pwm", s0, 0);
    en = 1'b1;
    @(negedge clk);
    check("post_rst_start_tick", int'(tick0), 1);
    repeat (3) @(negedge clk);

    finish_run();
  end

  // Hard bound on total simulated time.
  initial begin
    #(100_000 * 10);
    $display("FAIL watchdog: got timeout, expected completion");
    miscompares++;
    finish_run();
  end

endmodule : tb_servo_pwm_driver
`default_nettype wire
